// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: scan coordinates, active-video flag and sync pulses.
// Optional macro VGA_SYNC_PIPE_ALIGN_EN delays hs/vs by two clocks to match renderer colour latency.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic [9:0] hc_nxt;
    logic [9:0] vc_nxt;
    logic       hs_p0;
    logic       vs_p0;

    always_comb begin
        hc_nxt = DrawX + 10'd1;
        vc_nxt = DrawY;
        if (DrawX == H_LAST) begin
            hc_nxt = '0;
            vc_nxt = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
        end
    end

    // Stage p0: counters plus decodes of the next counter values, so flags share the cycle of DrawX/DrawY
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            hs_p0       <= 1'b1;
            vs_p0       <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            DrawX       <= hc_nxt;
            DrawY       <= vc_nxt;
            hs_p0       <= ~in_range(hc_nxt, HS_FIRST, HS_LAST);
            vs_p0       <= ~in_range(vc_nxt, VS_FIRST, VS_LAST);
            blank       <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
            frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
            line_start  <= (hc_nxt == '0);
        end
    end

`ifdef VGA_SYNC_PIPE_ALIGN_EN
    logic hs_p1, vs_p1, hs_p2, vs_p2;

    // Stages p1/p2: sync delay matching ROM read plus colour output register
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_p1 <= 1'b1;
            vs_p1 <= 1'b1;
            hs_p2 <= 1'b1;
            vs_p2 <= 1'b1;
        end else begin
            hs_p1 <= hs_p0;
            vs_p1 <= vs_p0;
            hs_p2 <= hs_p1;
            vs_p2 <= vs_p1;
        end
    end

    assign hs = hs_p2;
    assign vs = vs_p2;
`else
    assign hs = hs_p0;
    assign vs = vs_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunk-timing instance and a default-timing instance checked
// every cycle against a position-from-time reference model, with random async resets.
module tb_vga_timing_gen;

    typedef struct packed {
        int hv; int hf; int hsw; int hb;
        int vv; int vf; int vsw; int vb;
    } cfg_t;

    localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VV = 12, S_VF = 3, S_VS = 2, S_VB = 4;
    localparam cfg_t CS = '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB};
    localparam cfg_t CD = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);

`ifdef VGA_SYNC_PIPE_ALIGN_EN
    localparam int SYNC_LAG = 2;
`else
    localparam int SYNC_LAG = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] s_x, s_y, d_x, d_y;
    logic       s_hs, s_vs, s_blank, s_fs, s_ls;
    logic       d_hs, d_vs, d_blank, d_fs, d_ls;

    int checks = 0;
    int errors = 0;
    int t = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut (
        .vga_clk(clk), .reset(reset), .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs),
        .blank(s_blank), .frame_start(s_fs), .line_start(s_ls)
    );

    vga_timing_gen dut_def (
        .vga_clk(clk), .reset(reset), .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs),
        .blank(d_blank), .frame_start(d_fs), .line_start(d_ls)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    // Model: after release, clock n lands on scan position n of an endless raster.
    function automatic void model_pos(input cfg_t c, input int n, output int x, output int y);
        int ht, vt;
        ht = c.hv + c.hf + c.hsw + c.hb;
        vt = c.vv + c.vf + c.vsw + c.vb;
        x = (n <= 0) ? 0 : n % ht;
        y = (n <= 0) ? 0 : (n / ht) % vt;
    endfunction

    function automatic logic [1:0] model_sync(input cfg_t c, input int n);
        int x, y;
        if (n <= 0) return 2'b11;
        model_pos(c, n, x, y);
        return {!(x >= c.hv + c.hf && x < c.hv + c.hf + c.hsw),
                !(y >= c.vv + c.vf && y < c.vv + c.vf + c.vsw)};
    endfunction

    task automatic check_one(input string tag, input cfg_t c, input int ox, input int oy,
                             input int ohs, input int ovs, input int ob, input int ofs,
                             input int ols);
        int x, y;
        logic [1:0] sy;
        model_pos(c, t, x, y);
        sy = model_sync(c, t - SYNC_LAG);
        check({tag, ".x"}, ox, x);
        check({tag, ".y"}, oy, y);
        check({tag, ".hs"}, ohs, int'(sy[1]));
        check({tag, ".vs"}, ovs, int'(sy[0]));
        check({tag, ".blank"}, ob, (t > 0 && x < c.hv && y < c.vv) ? 1 : 0);
        check({tag, ".fs"}, ofs, (t > 0 && x == 0 && y == 0) ? 1 : 0);
        check({tag, ".ls"}, ols, (t > 0 && x == 0) ? 1 : 0);
    endtask

    task automatic check_all(input string tag);
        check_one({tag, ".s"}, CS, int'(s_x), int'(s_y), int'(s_hs), int'(s_vs),
                  int'(s_blank), int'(s_fs), int'(s_ls));
        check_one({tag, ".d"}, CD, int'(d_x), int'(d_y), int'(d_hs), int'(d_vs),
                  int'(d_blank), int'(d_fs), int'(d_ls));
    endtask

    initial begin
        int blank_cnt, vs_low_cnt, fs_cnt, fs_first, fs_last, hs_low_def, ls_def;
        blank_cnt = 0; vs_low_cnt = 0; fs_cnt = 0; fs_first = 0; fs_last = 0;
        hs_low_def = 0; ls_def = 0;

        reset = 1'b1;
        t = 0;
        repeat (10) begin
            @(posedge clk); #1;
            check_all("rst");
        end
        reset = 1'b0;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk); #1;
            t++;
            check_all("run");

            if (cyc < 2 * S_FRAME) begin
                if (t <= S_FRAME && s_blank) blank_cnt++;
                if (t <= S_FRAME && !s_vs) vs_low_cnt++;
                if (s_fs) begin
                    if (fs_cnt == 0) fs_first = t;
                    fs_last = t;
                    fs_cnt++;
                end
                if (t <= 800 && !d_hs) hs_low_def++;
                if (t <= 1600 && d_ls) ls_def++;
                if (t == S_FRAME) begin
                    check("blank_per_frame", blank_cnt, S_HV * S_VV);
                    check("vs_low_per_frame", vs_low_cnt, S_VS * (S_HV + S_HF + S_HS + S_HB));
                end
                if (t == 800) check("def_hs_low_per_line", hs_low_def, 96);
                if (t == 1600) check("def_ls_per_2lines", ls_def, 2);
                if (t == 2 * S_FRAME) begin
                    check("fs_count_2frames", fs_cnt, 2);
                    check("fs_spacing", fs_last - fs_first, S_FRAME);
                end
            end

            if (cyc == 2000 || (cyc > 2 * S_FRAME + 10 && $urandom_range(0, 299) == 0)) begin
                #2 reset = 1'b1;
                #1 t = 0;
                check_all("async");
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                    check_all("hold");
                end
                reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing generator feeding every sprite/background renderer in the display path.
- Produces the `DrawX`/`DrawY` scan coordinates, the active-video flag `blank`, and the `hs`/`vs` sync pulses.
- `blank`=1 means visible pixel; renderers gate colour with it.
- Default timing is 640x480 @ 60 Hz on the 25 MHz `vga_clk`.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- vga_clk  in  1  pixel clock; all state on its rising edge
- reset  in  1  asynchronous, active-high reset
- DrawX  out  10  current horizontal count (0..H_TOTAL-1)
- DrawY  out  10  current vertical count (0..V_TOTAL-1)
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE)
- frame_start  out  1  one-cycle pulse when DrawX=0 and DrawY=0
- line_start  out  1  one-cycle pulse when DrawX=0

Behaviour:
- Derived widths: H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be ≤1024.
- Reset values, held while reset=1: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, line_start=0.
- Horizontal counter hc increments every clock. At H_TOTAL-1 it wraps to 0 on the next edge.
- Vertical counter vc increments only on the hc wrap edge. At hc wrap with vc=V_TOTAL-1, vc wraps to 0.
- DrawX=hc, DrawY=vc, both driven directly from registers.
- hs, vs, blank, frame_start and line_start are registered decodes of the next counter values, so they align exactly with the DrawX/DrawY of the same cycle. Zero relative skew.
- hs=0 iff H_VISIBLE+H_FP ≤ hc ≤ H_VISIBLE+H_FP+H_SYNC-1 (656..751).
- vs=0 iff V_VISIBLE+V_FP ≤ vc ≤ V_VISIBLE+V_FP+V_SYNC-1 (490..491).
- vs transitions coincide with hc=0.
- blank=1 iff hc<H_VISIBLE and vc<V_VISIBLE.
- line_start=1 iff hc=0 (not during reset).
- frame_start=1 iff hc=0 and vc=0 (not during reset).
- First edge after reset release: counters advance to (1,0) and blank=1. Pixel (0,0) of the first frame stays blanked, and frame_start does not fire until the next frame wrap.
- Reset asserted mid-frame: outputs immediately (asynchronously) return to reset values. No partial-state carry-over.
- Frame period is H_TOTAL*V_TOTAL = 420000 clocks. Line period is 800 clocks.

Optional Feature:
- Macro: VGA_SYNC_PIPE_ALIGN_EN.
- Defined: hs and vs pass through an additional 2-stage register pipeline; both stages reset to 1. This aligns sync with renderer colour, which lags DrawX by 2 clocks (ROM read plus output register). DrawX, DrawY, blank, frame_start and line_start are unchanged.
- Undefined: hs/vs align with DrawX as specified above. No extra registers.

Test Plan:
- Reset held 10 cycles, then released → during reset all outputs at reset values. First post-release cycle: DrawX=1, DrawY=0, blank=1, hs=1.
- Run one full line → DrawX reaches 799 then 0 with DrawY +1. hs=0 exactly for DrawX 656..751 (96 clocks). blank=0 for DrawX 640..799. line_start pulses once per 800 clocks.
- Run 2 full frames → DrawY wraps 524→0. vs=0 for exactly 1600 clocks (DrawY 490..491). frame_start pulses exactly once, 420000 clocks apart. Count of blank=1 clocks per full frame = 307200.
- Assert reset at DrawX=300, DrawY=200 for 3 cycles → outputs go to reset values without waiting for a clock edge. After release, counting resumes from (1,0).
- Check wrap boundary (DrawX=799, DrawY=524) → next cycle (0,0) with frame_start=1, line_start=1, blank=1, hs=1, vs=1.
- With VGA_SYNC_PIPE_ALIGN_EN defined → first hs=0 appears when DrawX=658 and hs returns to 1 at DrawX=754. blank timing identical to the undefined build.
